// File: rtl/d_sram2sram_like_wbuf_if.sv
// d_sram2sram_like_wbuf_if: SRAM-like data bus between the bridge (master) and the data cache (slave).
interface d_sram2sram_like_wbuf_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              addr_ok;
  logic              data_ok;
  modport master(output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave(input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/d_sram2sram_like_wbuf.sv
// d_sram2sram_like_wbuf: CPU SRAM data port to SRAM-like bus bridge with a posted write buffer.
// Optional macro D_WBUF_FWD_EN: loads hitting a newest full-word buffered store are served from the buffer.
module d_sram2sram_like_wbuf #(
  parameter int ADDR_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpu_ram_ce_i,
  input  logic [ADDR_W-1:0]       cpu_ram_addr_i,
  input  logic [31:0]             cpu_ram_wdata_i,
  input  logic [3:0]              cpu_ram_sel_i,
  input  logic                    stall_all_i,
  output logic                    cpu_ram_stall_o,
  output logic [31:0]             cpu_ram_data_o,
  d_sram2sram_like_wbuf_if.master cache,
  output logic                    wbuf_empty_o
);
  localparam int PW = $clog2(WBUF_DEPTH);
  typedef enum logic [2:0] {IDLE, WREQ, WWAIT, RREQ, RWAIT} state_e;
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q [WBUF_DEPTH];
  logic [31:0]       data_q [WBUF_DEPTH];
  logic [3:0]        sel_q  [WBUF_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [PW:0]       cnt_q, cnt_d;
  logic              done_q, req_q, wr_q;
  logic [31:0]       rdata_save_q;
  logic              full, enq, deq, rd_pend, rd_ok, fwd;
  logic [31:0]       fwd_data;

  function automatic logic [1:0] size_of(input logic [3:0] s);
    return (s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) ? 2'd0 :
           (s inside {4'b0011, 4'b1100}) ? 2'd1 : 2'd2;
  endfunction

  // A same-cycle pop does not free a slot for this cycle's push.
  assign full    = cnt_q == (PW+1)'(WBUF_DEPTH);
  assign enq     = cpu_ram_ce_i & |cpu_ram_sel_i & ~done_q & ~full;
  assign rd_pend = cpu_ram_ce_i & ~|cpu_ram_sel_i & ~done_q;
  assign deq     = cache.data_ok & ((state_q == WWAIT) | (state_q == WREQ & cache.addr_ok));
  assign rd_ok   = cache.data_ok & ((state_q == RWAIT) | (state_q == RREQ & cache.addr_ok));
  assign cnt_d   = cnt_q + (PW+1)'(enq) - (PW+1)'(deq);

`ifdef D_WBUF_FWD_EN
  logic          hit;
  logic [PW-1:0] hit_idx;
  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = rp_q;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if ((PW+1)'(k) < cnt_q && addr_q[rp_q + PW'(k)][ADDR_W-1:2] == cpu_ram_addr_i[ADDR_W-1:2]) begin
        hit     = 1'b1;
        hit_idx = rp_q + PW'(k);
      end
    end
  end
  assign fwd      = rd_pend & hit & (sel_q[hit_idx] == 4'hf);
  assign fwd_data = data_q[hit_idx];
`else
  assign fwd      = 1'b0;
  assign fwd_data = '0;
`endif

  assign cpu_ram_stall_o = cpu_ram_ce_i & ~done_q & ~enq;
  assign cpu_ram_data_o  = rdata_save_q;
  assign wbuf_empty_o    = (cnt_q == '0) & (state_q != WREQ) & (state_q != WWAIT);
  assign cache.req       = req_q;
  assign cache.wr        = wr_q;
  assign cache.addr      = wr_q ? addr_q[rp_q] : cpu_ram_addr_i;
  assign cache.wdata     = data_q[rp_q];
  assign cache.size      = wr_q ? size_of(sel_q[rp_q]) : 2'd2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + PW'(enq);
      rp_q  <= rp_q + PW'(deq);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_q[wp_q] <= cpu_ram_addr_i;
      data_q[wp_q] <= cpu_ram_wdata_i;
      sel_q[wp_q]  <= cpu_ram_sel_i;
    end
  end

  // done keeps a held request from being replayed while the pipeline is globally stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      wr_q         <= 1'b0;
      done_q       <= 1'b0;
      rdata_save_q <= '0;
    end else begin
      done_q <= (enq & stall_all_i) | rd_ok | fwd | (done_q & stall_all_i);
      if (rd_ok) rdata_save_q <= cache.rdata;
      else if (fwd) rdata_save_q <= fwd_data;
      case (state_q)
        IDLE: begin
          if (cnt_q != '0) begin
            state_q <= WREQ;
            req_q   <= 1'b1;
            wr_q    <= 1'b1;
          end else if (rd_pend) begin
            state_q <= RREQ;
            req_q   <= 1'b1;
            wr_q    <= 1'b0;
          end
        end
        WREQ, RREQ: begin
          if (cache.addr_ok) begin
            req_q   <= 1'b0;
            state_q <= cache.data_ok ? IDLE : (state_q == WREQ ? WWAIT : RWAIT);
          end
        end
        WWAIT, RWAIT: if (cache.data_ok) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
